// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   start, op           - operation request (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   rs_val, rt_val      - operands (multiplicand/dividend, multiplier/divisor)
//   mthi, mtlo, wdata   - direct writes into HI/LO while idle
//   busy, done          - operation in progress / one-cycle completion pulse
//   hi, lo              - HI/LO result registers
//   div_by_zero         - last completed divide had a zero divisor
module muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
    state_t state, state_n;
    logic [4:0]  cnt;
    logic [1:0]  op_r;
    logic [31:0] rs_r, rt_r, a_mag, b_mag;
    logic [63:0] p, p_next, prod;
    logic [32:0] mul_sum, div_sh, div_diff;
    logic        sgn;

    // Magnitude of a possibly-signed operand; 0x80000000 stays 0x80000000 as unsigned.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? -v : v;
    endfunction

    assign sgn   = op_r[0];
    assign a_mag = mag(rs_r, sgn);
    assign b_mag = mag(rt_r, sgn);

    // p holds {upper accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, p[63:32]} + (p[0] ? {1'b0, a_mag} : 33'd0);
        div_sh   = {p[63:32], p[31]};
        div_diff = div_sh - {1'b0, b_mag};
        p_next   = (state == MUL) ? {mul_sum, p[31:1]} :
                   div_diff[32]   ? {div_sh[31:0], p[30:0], 1'b0} :
                                    {div_diff[31:0], p[30:0], 1'b1};
        prod     = (sgn && (rs_r[31] ^ rt_r[31])) ? -p : p;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? (op[1] ? DIV : MUL) : IDLE;
            MUL:     state_n = (cnt == 5'(ITER - 1)) ? FIN : MUL;
            DIV:     state_n = (cnt == 5'(ITER - 1)) ? FIN : DIV;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
            cnt         <= '0;
            p           <= '0;
            op_r        <= '0;
            rs_r        <= '0;
            rt_r        <= '0;
        end else begin
            done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        rs_r <= rs_val;
                        rt_r <= rt_val;
                        cnt  <= '0;
                        p    <= {32'd0, op[1] ? mag(rs_val, op[0]) : mag(rt_val, op[0])};
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                MUL, DIV: begin
                    p   <= p_next;
                    cnt <= cnt + 5'd1;
                end
                default: begin
                    if (!op_r[1]) begin
                        {hi, lo} <= prod;
                    end else if (rt_r == 32'd0) begin
                        // Restoring divide by zero yields all-ones quotient; remainder is the raw dividend.
                        lo          <= 32'hFFFF_FFFF;
                        hi          <= rs_r;
                        div_by_zero <= 1'b1;
                    end else begin
                        lo          <= (sgn && (rs_r[31] ^ rt_r[31])) ? -p[31:0] : p[31:0];
                        hi          <= (sgn && rs_r[31]) ? -p[63:32] : p[63:32];
                        div_by_zero <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven, hand-sequenced and randomized checks of muldiv_unit.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic        m_dbz = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs, rt, hi, lo;
        logic        dbz;
    } vec_t;
    vec_t tbl[11];

    muldiv_unit #(.ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operation's definition.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] x;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'd0) begin
            x = 64'(a) * 64'(b);
            {m_hi, m_lo} = x;
        end else if (o == 2'd1) begin
            x = 64'(sa * sb);
            {m_hi, m_lo} = x;
        end else if (b == 0) begin
            m_lo = 32'hFFFF_FFFF; m_hi = a; m_dbz = 1'b1;
        end else if (o == 2'd2) begin
            m_lo = a / b; m_hi = a % b; m_dbz = 1'b0;
        end else begin
            q = sa / sb; r = sa % sb;
            m_lo = q[31:0]; m_hi = r[31:0]; m_dbz = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after an edge; start is sampled at the next edge. Returns #1 after the done edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic mv);
        logic [31:0] h0, l0;
        int n;
        bit bad_busy, bad_hold;
        h0 = hi; l0 = lo; bad_busy = 0; bad_hold = 0;
        start = 1'b1; op = o; rs_val = a; rt_val = b; mthi = mv; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (!busy) bad_busy = 1;
            if (hi !== h0 || lo !== l0) bad_hold = 1;
            start = 1'($urandom); op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
            mthi = 1'($urandom); mtlo = 1'($urandom); wdata = $urandom;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("latency", 64'(n), 64'd34);
        chk("busy_during_op", 64'(bad_busy), 64'd0);
        chk("hold_during_op", 64'(bad_hold), 64'd0);
        chk("busy_at_done", 64'(busy), 64'd0);
        model(o, a, b);
        chk("hi_model", 64'(hi), 64'(m_hi));
        chk("lo_model", 64'(lo), 64'(m_lo));
        chk("dbz_model", 64'(div_by_zero), 64'(m_dbz));
    endtask

    initial begin
        bit seen_done;
        logic [31:0] h0;
        tbl[0]  = '{2'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[2]  = '{2'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3]  = '{2'd2, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0};
        tbl[4]  = '{2'd2, 32'h1234,      32'd0,        32'h1234,      32'hFFFF_FFFF, 1'b1};
        tbl[5]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b1};
        tbl[6]  = '{2'd2, 32'd9,         32'd3,        32'd0,         32'd3,         1'b0};
        tbl[7]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
        tbl[8]  = '{2'd3, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        tbl[9]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
        tbl[10] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};

        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0;
        rs_val = 0; rt_val = 0; wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, 1'b0);
            chk($sformatf("tbl%0d_hi", i), 64'(hi), 64'(tbl[i].hi));
            chk($sformatf("tbl%0d_lo", i), 64'(lo), 64'(tbl[i].lo));
            chk($sformatf("tbl%0d_dbz", i), 64'(div_by_zero), 64'(tbl[i].dbz));
        end
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);

        // mtlo/mthi while idle take effect at the next edge
        mtlo = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        mtlo = 1'b0;
        chk("mtlo_idle", 64'(lo), 64'h55);
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        mthi = 1'b0;
        chk("mthi_idle", 64'(hi), 64'h1234_5678);
        m_hi = 32'h1234_5678; m_lo = 32'h55;

        // start with a simultaneous move: operation runs, move discarded
        run_op(2'd0, 32'd3, 32'd4, 1'b1);

        // set div_by_zero so the reset check below is meaningful
        run_op(2'd2, 32'd77, 32'd0, 1'b0);

        // mid-operation reset; mthi while busy ignored
        start = 1'b1; op = 2'd0; rs_val = 5; rt_val = 5;
        @(posedge clk); #1;
        start = 1'b0;
        h0 = hi;
        repeat (9) @(posedge clk);
        #1;
        mthi = 1'b1; wdata = 32'hAA;
        @(posedge clk); #1;
        mthi = 1'b0;
        chk("mthi_busy_ignored", 64'(hi), 64'(h0));
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midop_rst_hi", 64'(hi), 64'd0);
        chk("midop_rst_lo", 64'(lo), 64'd0);
        chk("midop_rst_busy", 64'(busy), 64'd0);
        chk("midop_rst_dbz", 64'(div_by_zero), 64'd0);
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        chk("midop_rst_no_done", 64'(seen_done), 64'd0);
        m_hi = 0; m_lo = 0; m_dbz = 0;

        // start together with reset is ignored
        rst = 1'b1; start = 1'b1; op = 2'd3; rs_val = 10; rt_val = 3;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("start_with_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("start_with_rst_busy2", 64'(busy), 64'd0);

        // randomized back-to-back operations against the model
        for (int k = 0; k < 40; k++) run_op(2'($urandom), pick(), pick(), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter ITER, default 32, SHALL set the number of iteration cycles per operation; only 32 is supported.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005 op  input  2  SHALL encode the operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 rs_val  input  32  SHALL carry the first operand, register-file Read1 (multiplicand/dividend).
REQ-007 rt_val  input  32  SHALL carry the second operand, register-file Read2 (multiplier/divisor).
REQ-008 mthi  input  1  SHALL request a write of wdata into HI.
REQ-009 mtlo  input  1  SHALL request a write of wdata into LO.
REQ-010 wdata  input  32  SHALL carry the data for mthi/mtlo.
REQ-011 busy  output  1  SHALL be high while an operation is in progress.
REQ-012 done  output  1  SHALL be a one-cycle completion pulse.
REQ-013 hi  output  32  SHALL present the HI register.
REQ-014 lo  output  32  SHALL present the LO register.
REQ-015 div_by_zero  output  1  SHALL flag that the last completed divide had rt_val == 0.

Function
REQ-016 FSM states SHALL be IDLE, MUL, DIV and FIN, with IDLE as the reset state.
REQ-017 IDLE with start=1 SHALL latch op, rs_val and rt_val, then go to MUL (op[1]=0) or DIV (op[1]=1); busy SHALL be high from the next cycle.
REQ-018 MUL/DIV SHALL iterate exactly 32 cycles (shift-add multiply, restoring divide, one bit per cycle), then go to FIN.
REQ-019 FIN SHALL last one cycle: sign correction, hi/lo/div_by_zero updated at its closing edge, done=1 during the following cycle, busy=0 in that same cycle, state returns to IDLE.
REQ-020 Latency SHALL be fixed: done asserts 34 cycles after the cycle in which start was sampled; a new start is accepted in the done cycle.
REQ-021 MULTU/MULT SHALL produce the 64-bit product: {hi,lo} = rs*rt, unsigned or two's-complement respectively.
REQ-022 Signed ops SHALL operate on magnitudes and negate at FIN; a negative operand of 0x80000000 SHALL be handled without overflow.
REQ-023 DIVU/DIV SHALL produce lo = quotient and hi = remainder; signed quotient SHALL truncate toward zero and the remainder SHALL take the dividend's sign.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-025 Divide by zero SHALL still take full latency and yield lo=0xFFFFFFFF, hi=rs_val, div_by_zero=1; any non-zero divide SHALL clear div_by_zero, and multiplies SHALL leave it unchanged.
REQ-026 start while busy SHALL be ignored; operand changes while busy SHALL have no effect.
REQ-027 mthi/mtlo in IDLE SHALL update hi/lo at the next edge; mthi/mtlo while busy SHALL be ignored.
REQ-028 start together with mthi/mtlo in IDLE SHALL start the operation and discard the move.
REQ-029 hi and lo SHALL hold their previous values for the whole operation until the FIN update.

Reset
REQ-030 rst=1 at any edge, including mid-operation, SHALL force IDLE, hi=0, lo=0, busy=0, done=0 and div_by_zero=0, and discard the in-flight operation.
REQ-031 start asserted together with rst SHALL be ignored.

Verification
REQ-032 MULT rs=0xFFFFFFFD (-3), rt=7 -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high for cycles 1..33.
REQ-033 MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=100, rt=7 -> lo=14, hi=2.
REQ-035 DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; next DIVU 9/3 -> lo=3, hi=0, div_by_zero=0.
REQ-036 start MULTU 5*5, then mthi wdata=0xAA at cycle 10 and rst pulse at cycle 20 -> mthi ignored, done never pulses, hi=lo=0, busy=0 after reset.
REQ-037 mtlo wdata=0x55 in IDLE -> lo=0x55 next cycle; start+mthi in the same cycle -> operation runs and hi is only written at FIN.
